// File: rtl/digit_serial_addsub.sv
// Nibble-serial add/subtract; the result is streamed LSB-computed, MSB-first as ASCII hex over valid/ready.
// Optional feature macro CRLF_EN: append CR, LF after the hex digits.
module digit_serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             Gl_rst_n,
   input  logic             Gl_adder_start,
   input  logic             Gl_subtract,
   input  logic [WIDTH-1:0] Gl_r1,
   input  logic [WIDTH-1:0] Gl_r2,
   input  logic             Gl_char_rdy,
   output logic [7:0]       L2_char,
   output logic             L2_char_vld,
   output logic             L2_busy,
   output logic             L2_done,
   output logic [7:0]       L2_led
);
   localparam int NDIG = WIDTH / 4;
`ifdef CRLF_EN
   localparam int NCHAR = NDIG + 3;
`else
   localparam int NCHAR = NDIG + 1;
`endif
   localparam int CW = $clog2(NCHAR + 1);

   typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;
   typedef struct packed {
      logic             sub;
      logic [WIDTH-1:0] r1;
      logic [WIDTH-1:0] r2;
   } req_t;

   state_t           state, state_nxt;
   req_t             req_q;
   logic [WIDTH-1:0] res_q, res_nxt;
   logic             carry_q, flag_q, flag_nxt;
   logic [CW-1:0]    dig_q, ch_q;
   logic [7:0]       led_q;
   logic [3:0]       a_dig, b_dig, e_dig;
   logic [4:0]       sum;
   logic [6:0]       led_res;
   logic             last_dig, last_ch, xfer;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign last_dig = (dig_q == CW'(NDIG - 1));
   assign last_ch  = (ch_q == CW'(NCHAR - 1));
   assign xfer     = (state == EMIT) && Gl_char_rdy;
   assign flag_nxt = req_q.sub ? ~sum[4] : sum[4];
   assign L2_led   = led_q;

   // Digit muxes: operand nibble for CALC, result nibble for the current EMIT slot.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      e_dig = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig_q == CW'(i)) begin
            a_dig = req_q.r1[i*4 +: 4];
            b_dig = req_q.r2[i*4 +: 4];
         end
         if (ch_q == CW'(NDIG - i)) e_dig = res_q[i*4 +: 4];
      end
      sum = {1'b0, a_dig} + {1'b0, (req_q.sub ? ~b_dig : b_dig)} + {4'h0, carry_q};
      res_nxt = res_q;
      for (int i = 0; i < NDIG; i++)
         if (dig_q == CW'(i)) res_nxt[i*4 +: 4] = sum[3:0];
   end

   if (WIDTH >= 8) begin : g_led_wide
      assign led_res = res_nxt[6:0];
   end else begin : g_led_narrow
      assign led_res = {3'b000, res_nxt[3:0]};
   end

   always_ff @(posedge clk or negedge Gl_rst_n) begin
      if (!Gl_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      L2_char     = 8'h00;
      L2_char_vld = 1'b0;
      L2_done     = 1'b0;
      L2_busy     = (state != IDLE);
      case (state)
         IDLE: if (Gl_adder_start) state_nxt = CALC;
         CALC: if (last_dig) state_nxt = EMIT;
         EMIT: begin
            L2_char_vld = 1'b1;
            if (ch_q == '0) L2_char = flag_q ? 8'h31 : 8'h30;
`ifdef CRLF_EN
            else if (ch_q == CW'(NDIG + 1)) L2_char = 8'h0D;
            else if (ch_q == CW'(NDIG + 2)) L2_char = 8'h0A;
`endif
            else L2_char = hex_ascii(e_dig);
            if (xfer && last_ch) state_nxt = DONE;
         end
         DONE: begin
            L2_done   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Gl_rst_n) begin
      if (!Gl_rst_n) begin
         req_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         flag_q  <= 1'b0;
         dig_q   <= '0;
         ch_q    <= '0;
         led_q   <= '0;
      end else begin
         case (state)
            IDLE: if (Gl_adder_start) begin
               req_q   <= {Gl_subtract, Gl_r1, Gl_r2};
               carry_q <= Gl_subtract;  // +1 of the two's-complement negate
               dig_q   <= '0;
               ch_q    <= '0;
            end
            CALC: begin
               res_q   <= res_nxt;
               carry_q <= sum[4];
               dig_q   <= dig_q + CW'(1);
               if (last_dig) begin
                  flag_q <= flag_nxt;
                  led_q  <= {flag_nxt, led_res};
               end
            end
            EMIT: if (xfer) ch_q <= last_ch ? '0 : ch_q + CW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Randomised bench for digit_serial_addsub against an arithmetic reference model of the character stream.
module tb_digit_serial_addsub;
   localparam int W  = 8;
   localparam int ND = W / 4;

   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, rdy = 1'b1;
   logic [W-1:0] r1 = '0, r2 = '0;
   logic [7:0]   ch, led;
   logic         vld, busy, done;
   int           total = 0, bad = 0;

   digit_serial_addsub #(.WIDTH(W)) dut (
      .clk(clk), .Gl_rst_n(rst_n), .Gl_adder_start(start), .Gl_subtract(sub),
      .Gl_r1(r1), .Gl_r2(r2), .Gl_char_rdy(rdy),
      .L2_char(ch), .L2_char_vld(vld), .L2_busy(busy), .L2_done(done), .L2_led(led)
   );

   always #5 clk = ~clk;

   // One full operation: accept, latency, character stream, done pulse, return to idle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit rnd, input int stall_idx, input bit poke);
      byte unsigned exp_q[$];
      longint av, bv, sv, md;
      logic [W-1:0] res;
      logic [63:0]  rl;
      logic         flg;
      logic [7:0]   exp_led;
      int           lat, idx, guard, stall_left, nib;
      av = longint'(a); bv = longint'(b); md = longint'(1) << W;
      if (s) begin
         flg = (av < bv);
         res = W'((av - bv + md) % md);
      end else begin
         sv  = av + bv;
         flg = (sv >= md);
         res = W'(sv % md);
      end
      rl = 64'(res);
      exp_led = {flg, rl[6:0]};
      exp_q.push_back(flg ? 8'h31 : 8'h30);
      for (int d = ND - 1; d >= 0; d--) begin
         nib = int'((rl >> (4 * d)) & 64'hF);
         exp_q.push_back(nib < 10 ? byte'(48 + nib) : byte'(55 + nib));
      end
`ifdef CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
      @(negedge clk);
      start = 1'b1; r1 = a; r2 = b; sub = s; rdy = 1'b1;
      @(negedge clk);
      start = 1'b0; r1 = W'($urandom); r2 = W'($urandom); sub = 1'($urandom);
      lat = 1;
      while (!vld && lat <= 40) begin
         start = poke && (lat == 1);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      total++;
      if (lat != ND + 1) begin
         bad++;
         $display("FAIL latency a=%h b=%h sub=%b: got %0d want %0d", a, b, s, lat, ND + 1);
         if (!vld) return;
      end
      idx = 0; guard = 0; stall_left = 3;
      while (idx < exp_q.size() && guard < 200) begin
         total++;
         if (vld !== 1'b1 || ch !== exp_q[idx]) begin
            bad++;
            $display("FAIL char[%0d] a=%h b=%h sub=%b: got vld=%b ch=%h want vld=1 ch=%h",
                     idx, a, b, s, vld, ch, exp_q[idx]);
         end
         if (idx == stall_idx && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else begin
            rdy = rnd ? 1'($urandom) : 1'b1;
         end
         start = poke && (idx == 1);
         if (rdy) idx++;
         guard++;
         @(negedge clk);
      end
      start = 1'b0; rdy = 1'b1;
      if (guard >= 200) begin
         total++; bad++;
         $display("FAIL stream timeout: got %0d chars want %0d", idx, exp_q.size());
         return;
      end
      total++;
      if (done !== 1'b1 || vld !== 1'b0 || busy !== 1'b1 || led !== exp_led) begin
         bad++;
         $display("FAIL done a=%h b=%h sub=%b: got done=%b vld=%b busy=%b led=%h want 1 0 1 %h",
                  a, b, s, done, vld, busy, led, exp_led);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || vld !== 1'b0) begin
         bad++;
         $display("FAIL idle: got done=%b busy=%b vld=%b want 0 0 0", done, busy, vld);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({ch, vld, busy, done, led} !== 18'h0) begin
         bad++;
         $display("FAIL reset: got ch=%h vld=%b busy=%b done=%b led=%h want all 0", ch, vld, busy, done, led);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({ch, vld, busy, done, led} !== 18'h0) begin
         bad++;
         $display("FAIL post_reset: got ch=%h vld=%b busy=%b done=%b led=%h want all 0", ch, vld, busy, done, led);
      end
   endtask

   task automatic test_directed();
      do_op(8'h3C, 8'h25, 1'b0, 1'b0, -1, 1'b0);
      do_op(8'hF0, 8'h20, 1'b0, 1'b0, -1, 1'b0);
      do_op(8'h05, 8'h07, 1'b1, 1'b0, -1, 1'b0);
      do_op(8'h07, 8'h05, 1'b1, 1'b0, -1, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b0, 1'b0, -1, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1, 1'b0);
      do_op(8'h00, 8'h00, 1'b1, 1'b0, -1, 1'b0);
      do_op(8'h00, 8'hFF, 1'b1, 1'b0, -1, 1'b0);
   endtask

   task automatic test_stall();
      do_op(8'h3C, 8'h25, 1'b0, 1'b0, 1, 1'b0);
   endtask

   task automatic test_ignored_start();
      do_op(8'h3C, 8'h25, 1'b0, 1'b0, -1, 1'b1);
      do_op(8'h9A, 8'hC7, 1'b1, 1'b1, -1, 1'b1);
   endtask

   task automatic test_abort();
      int guard;
      @(negedge clk);
      start = 1'b1; r1 = 8'h3C; r2 = 8'h25; sub = 1'b0; rdy = 1'b0;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!vld && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({ch, vld, busy, done, led} !== 18'h0) begin
         bad++;
         $display("FAIL abort: got ch=%h vld=%b busy=%b done=%b led=%h want all 0", ch, vld, busy, done, led);
      end
      @(negedge clk);
      rst_n = 1'b1; rdy = 1'b1;
      do_op(8'h01, 8'h01, 1'b0, 1'b0, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_ignored_start();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
